// File: rtl/cfg_pkg.sv
// Shared types and helpers for the configuration scan-chain loader and its
// CRC-8 checkers.
package cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CRC   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  function automatic int calc_words(input int chain_len, input int word_width);
    return (chain_len + word_width - 1) / word_width;
  endfunction

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07): one step per valid bit.
// The clear input has priority over bit_valid and reloads CRC8_INIT.
module crc8_serial
  import cfg_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC8_INIT;
    end else if (bit_valid) begin
      crc_d = crc8_step(crc_q, bit_in);
    end
  end

  always_ff @(posedge clk) begin
    crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/cfg_scan_loader.sv
// Serializes configuration words onto the CLB scan chain, then checks a CRC-8 trailer.
// States: IDLE wait start | SHIFT serialize words | CRC await trailer | DONE report result.
module cfg_scan_loader
  import cfg_pkg::*;
#(
  parameter int CHAIN_LEN  = 29,
  parameter int WORD_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
)
(
  input  logic                  scan_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  scan_data,
  output logic                  scan_en,
  output logic                  busy,
  output logic                  done,
  output logic                  crc_err,
  output logic [CNT_WIDTH-1:0]  bit_count
);

  localparam int WORDS     = calc_words(CHAIN_LEN, WORD_WIDTH);
  localparam int LAST_BITS = CHAIN_LEN - (WORDS - 1) * WORD_WIDTH;
  localparam int IDX_W     = $clog2(WORD_WIDTH + 1);
  localparam int WC_W      = $clog2(WORDS + 1);

  localparam logic [IDX_W-1:0]     FULL_BITS_W   = IDX_W'(WORD_WIDTH);
  localparam logic [IDX_W-1:0]     LAST_BITS_W   = IDX_W'(LAST_BITS);
  localparam logic [WC_W-1:0]      WORDS_W       = WC_W'(WORDS);
  localparam logic [WC_W-1:0]      LAST_WORD_IDX = WC_W'(WORDS - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_BIT_CNT  = CNT_WIDTH'(CHAIN_LEN - 1);

  state_e                state_q,     state_d;
  logic [WORD_WIDTH-1:0] buf_q,       buf_d;
  logic [IDX_W-1:0]      bits_left_q, bits_left_d;
  logic [WC_W-1:0]       words_q,     words_d;
  logic [CNT_WIDTH-1:0]  bit_count_q, bit_count_d;
  logic                  scan_en_q,   scan_en_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;
  logic                  crc_err_q,   crc_err_d;

  logic       ready_c;
  logic       shift_now;
  logic       load_clear;
  logic       crc_bit_valid;
  logic [7:0] crc_val;

  crc8_serial u_crc (
    .clk       (scan_clk),
    .clear     (reset | load_clear),
    .bit_valid (crc_bit_valid),
    .bit_in    (buf_q[0]),
    .crc       (crc_val)
  );

  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    bits_left_d   = bits_left_q;
    words_d       = words_q;
    bit_count_d   = bit_count_q;
    done_d        = done_q;
    crc_err_d     = crc_err_q;
    ready_c       = 1'b0;
    load_clear    = 1'b0;
    crc_bit_valid = 1'b0;
    shift_now     = (bits_left_q != '0);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = SHIFT;
          buf_d       = '0;
          bits_left_d = '0;
          words_d     = '0;
          bit_count_d = '0;
          done_d      = 1'b0;
          crc_err_d   = 1'b0;
          load_clear  = 1'b1;
        end
      end
      SHIFT: begin
        ready_c = (words_q < WORDS_W) && (bits_left_q <= IDX_W'(1));
        if (shift_now) begin
          crc_bit_valid = 1'b1;
          bit_count_d   = bit_count_q + 1'b1;
          bits_left_d   = bits_left_q - 1'b1;
          // Clearing an emptied buffer keeps scan_data low and drops the unused
          // upper bits of the final word.
          buf_d         = (bits_left_q == IDX_W'(1)) ? '0 : (buf_q >> 1);
        end
        if (cfg_valid && ready_c) begin
          buf_d       = cfg_data;
          bits_left_d = (words_q == LAST_WORD_IDX) ? LAST_BITS_W : FULL_BITS_W;
          words_d     = words_q + 1'b1;
        end
        if (shift_now && (bit_count_q == LAST_BIT_CNT)) begin
          state_d = CRC;
        end
      end
      CRC: begin
        ready_c = 1'b1;
        if (cfg_valid) begin
          crc_err_d = (cfg_data[7:0] != crc_val);
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    scan_en_d = (bits_left_d != '0);
    busy_d    = (state_d == SHIFT) || (state_d == CRC);
  end

  always_ff @(posedge scan_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      buf_q       <= '0;
      bits_left_q <= '0;
      words_q     <= '0;
      bit_count_q <= '0;
      scan_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      crc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      bits_left_q <= bits_left_d;
      words_q     <= words_d;
      bit_count_q <= bit_count_d;
      scan_en_q   <= scan_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      crc_err_q   <= crc_err_d;
    end
  end

  assign cfg_ready = ready_c;
  assign scan_data = buf_q[0];
  assign scan_en   = scan_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign crc_err   = crc_err_q;
  assign bit_count = bit_count_q;

endmodule

// File: doc/cfg_scan_loader.md
Name: cfg_scan_loader

Overview:
- Upstream feeder of the CLB configuration scan chain.
- Accepts a configuration bitstream as parallel words over a valid/ready handshake and serializes it onto the chain's scan_in with scan_en gating.
- Counts exactly CHAIN_LEN shifted bits, then takes one trailer word and checks it against a CRC-8 computed over the shifted bits.
- Reports done/crc_err to the top-level configuration controller.

Parameters:
CHAIN_LEN, 29, total scan-chain bits; default matches one default CLB (1 is_comb + 12 conn + 16 LUT).
WORD_WIDTH, 8, input word width; must be >= 8.
CNT_WIDTH, 16, width of bit_count; must satisfy 2**CNT_WIDTH > CHAIN_LEN.

Ports:
scan_clk  input  1  single clock; chain shifts on posedge when scan_en=1.
reset  input  1  synchronous, active-high.
start  input  1  one-cycle pulse; begins a load, honoured only in IDLE or DONE.
cfg_data  input  WORD_WIDTH  bitstream word; bit 0 is shifted first.
cfg_valid  input  1  cfg_data valid.
cfg_ready  output  1  loader accepts word this cycle when cfg_valid & cfg_ready.
scan_data  output  1  drives chain scan_in.
scan_en  output  1  drives chain scan_en; high only when scan_data is a real bitstream bit.
busy  output  1  high in SHIFT and CRC states.
done  output  1  level; high in DONE until next start or reset.
crc_err  output  1  valid when done=1; 1 = trailer mismatch.
bit_count  output  CNT_WIDTH  bits shifted so far in current load.

Behaviour:
- Interface rule: one clock (scan_clk); reset is synchronous and active-high.
- Reset: state IDLE. All outputs 0: cfg_ready, scan_en, scan_data, busy, done, crc_err, bit_count. Word buffer empty. CRC = 0x00.
- Reset mid-operation:
  - Next edge forces IDLE and scan_en=0.
  - Chain contents are undefined afterwards; a full reload is required.
- States:
  - IDLE: start -> SHIFT. Clears bit_count, CRC, done, crc_err, words_accepted.
  - SHIFT:
    - Buffer holds at most one word plus a bit index.
    - cfg_ready = (words_accepted < WORDS) & (buffer empty | last used bit of current word shifts this cycle), where WORDS = ceil(CHAIN_LEN/WORD_WIDTH).
    - With continuous cfg_valid: no bubbles. A word accepted at cycle N shifts its bit 0 at cycle N+1.
    - When the buffer holds a bit: scan_en=1, scan_data=buf[idx]. Each such cycle: idx++, bit_count++, CRC updated with that bit.
    - Buffer empty: scan_en=0 and scan_data=0 (stall cycles are safe, the chain does not shift).
    - Final word: only CHAIN_LEN-(WORDS-1)*WORD_WIDTH low bits are shifted; remaining bits are discarded and never appear on scan_data.
    - When bit_count reaches CHAIN_LEN -> CRC.
  - CRC:
    - scan_en=0, cfg_ready=1.
    - On handshake: crc_err = (cfg_data[7:0] != CRC); -> DONE. Upper trailer bits are ignored.
  - DONE: done=1, busy=0, cfg_ready=0. start -> SHIFT (restart as in IDLE).
- start in SHIFT/CRC is ignored.
- cfg_valid outside SHIFT/CRC is ignored (cfg_ready=0).
- CRC-8 definition:
  - poly 0x07, init 0x00, serial, one step per shifted bit, in shift order.
  - fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00).
- Timing: scan_data and scan_en derive only from registers. There is no combinational path from cfg_* to scan_*.

Decomposition:
- Shared package cfg_pkg holds:
  - state enum {IDLE, SHIFT, CRC, DONE};
  - CRC8_POLY = 8'h07 and CRC8_INIT = 8'h00;
  - a function computing WORDS from CHAIN_LEN and WORD_WIDTH.
- One sub-module: crc8_serial (clk, clear, bit_valid, bit_in, crc[7:0]), reusable by a future readback checker.

Test Plan:
- Reset held 3 cycles, with start=1 and cfg_valid=1 -> all outputs 0, state IDLE, no scan_en pulse.
- CHAIN_LEN=8: start; word 0x01; trailer 0x89 -> scan_en high exactly 8 cycles; scan_data sequence 1,0,0,0,0,0,0,0; then done=1, crc_err=0, bit_count=8.
- CHAIN_LEN=8: same word, trailer 0x88 -> done=1, crc_err=1; a following start clears both and reloads correctly.
- Default CHAIN_LEN=29: words 0xA5,0x3C,0xFF,0xE1 back-to-back with constant valid, then trailer = reference-model CRC -> scan_en high 29 consecutive cycles; bits 5..7 of 0xE1 never shifted; bit_count=29; crc_err=0.
- Default CHAIN_LEN=29, same stream with 3-cycle cfg_valid gaps -> scan_en low during every gap; shifted bit sequence identical to the no-gap run; total scan_en-high cycles = 29.
- Reset asserted after 10 bits shifted, and a start pulse issued at bit 5 -> start ignored; on the edge after reset, state is IDLE with scan_en=0 and bit_count=0; a fresh load then completes with crc_err=0.
